reg_file_param: RTL

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param_if.sv | 47 ++++
 rtl/reg_file_param.sv | 117 +++++++++++
 2 files changed

// File: rtl/reg_file_param_if.sv
// Register-file bus: two read ports with a shared read enable, a byte-lane
// write port A, a full-word write port B, and the status outputs.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();

  localparam int NREG  = 2 ** ADDR_W;
  localparam int NBYTE = DATA_W / 8;

  // Read side
  logic                     ReadEn;
  logic [ADDR_W-1:0]        ReadReg1;
  logic [ADDR_W-1:0]        ReadReg2;
  logic signed [DATA_W-1:0] ReadData1;
  logic signed [DATA_W-1:0] ReadData2;

  // Write port A (byte lanes)
  logic                     WriteEnA;
  logic [ADDR_W-1:0]        WriteRegA;
  logic [NBYTE-1:0]         ByteEnA;
  logic signed [DATA_W-1:0] WriteDataA;

  // Write port B (full word)
  logic                     WriteEnB;
  logic [ADDR_W-1:0]        WriteRegB;
  logic signed [DATA_W-1:0] WriteDataB;

  // Status
  logic [NREG-1:0]          Written;
  logic                     Collision;

  modport master (
    output ReadEn, ReadReg1, ReadReg2,
    output WriteEnA, WriteRegA, ByteEnA, WriteDataA,
    output WriteEnB, WriteRegB, WriteDataB,
    input  ReadData1, ReadData2, Written, Collision
  );

  modport slave (
    input  ReadEn, ReadReg1, ReadReg2,
    input  WriteEnA, WriteRegA, ByteEnA, WriteDataA,
    input  WriteEnB, WriteRegB, WriteDataB,
    output ReadData1, ReadData2, Written, Collision
  );

endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file: two write ports (A byte-lane, B full word,
// B wins on address clash), two registered read ports with write-through,
// per-register written flags and a registered collision pulse.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            Clk,
  input  logic            Rst,
  reg_file_param_if.slave bus
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int NBYTE = DATA_W / 8;
  localparam bit ZR    = (ZERO_REG != 0);

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic signed [DATA_W-1:0] merge_bytes(
    input logic signed [DATA_W-1:0] old_w,
    input logic signed [DATA_W-1:0] new_w,
    input logic [NBYTE-1:0]         be
  );
    logic signed [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NBYTE; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // Read value seen at the port: register 0 is hard-wired when ZERO_REG is set.
  function automatic logic signed [DATA_W-1:0] read_word(
    input logic [ADDR_W-1:0]        addr,
    input logic signed [DATA_W-1:0] word
  );
    if (ZR && (addr == '0)) return '0;
    return word;
  endfunction

  logic signed [DATA_W-1:0] mem     [NREG];
  logic signed [DATA_W-1:0] mem_nxt [NREG];
  logic signed [DATA_W-1:0] rd1_p1;
  logic signed [DATA_W-1:0] rd2_p1;
  logic [NREG-1:0]          written_p1;
  logic [NREG-1:0]          written_nxt;
  logic                     coll_p1;

  // rst_pulse_q is set by reset and cleared by the first clock edge that
  // follows. rst_smp_q is Rst as seen at the previous edge. Together they tell
  // a reset that was pulsed between two edges (the write presented in that
  // cycle must be thrown away) from a reset that was held across an edge
  // (the first edge after release captures normally).
  logic rst_pulse_q;
  logic rst_smp_q;
  logic discard;

  logic acc_a;
  logic acc_b;
  logic coll_nxt;

  assign discard = rst_pulse_q & ~rst_smp_q;

  // A write is accepted when enabled, not discarded and not aimed at a
  // hard-wired register 0.
  assign acc_a = bus.WriteEnA && !discard && !(ZR && (bus.WriteRegA == '0));
  assign acc_b = bus.WriteEnB && !discard && !(ZR && (bus.WriteRegB == '0));

  assign coll_nxt = acc_a && acc_b && (bus.WriteRegA == bus.WriteRegB);

  // Post-write register image; B is applied last so it wins every lane on a clash.
  always_comb begin
    mem_nxt = mem;
    if (acc_a) mem_nxt[bus.WriteRegA] = merge_bytes(mem[bus.WriteRegA], bus.WriteDataA, bus.ByteEnA);
    if (acc_b) mem_nxt[bus.WriteRegB] = bus.WriteDataB;
  end

  // Written flags accumulate every accepted write, including empty byte masks.
  always_comb begin
    written_nxt = written_p1;
    if (acc_a) written_nxt[bus.WriteRegA] = 1'b1;
    if (acc_b) written_nxt[bus.WriteRegB] = 1'b1;
  end

  // Sample Rst at each edge to qualify the mid-cycle reset detector.
  always_ff @(posedge Clk) begin
    rst_smp_q <= Rst;
  end

  // ---- stage p1: storage update, write-through read capture, status ----
  // Register array, read outputs and status flags, all cleared by reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      rd1_p1      <= '0;
      rd2_p1      <= '0;
      written_p1  <= '0;
      coll_p1     <= 1'b0;
      rst_pulse_q <= 1'b1;
    end else begin
      mem         <= mem_nxt;
      written_p1  <= written_nxt;
      coll_p1     <= coll_nxt;
      rst_pulse_q <= 1'b0;
      if (bus.ReadEn) begin
        rd1_p1 <= read_word(bus.ReadReg1, mem_nxt[bus.ReadReg1]);
        rd2_p1 <= read_word(bus.ReadReg2, mem_nxt[bus.ReadReg2]);
      end
    end
  end

  assign bus.ReadData1 = rd1_p1;
  assign bus.ReadData2 = rd2_p1;
  assign bus.Written   = written_p1;
  assign bus.Collision = coll_p1;

endmodule
